// File: rtl/rom_bank_loader.sv
// Banked synchronous-read image memory with a byte-serial run-time loader.
// NUM_BANKS images of DEPTH words share one block RAM; the CPU reads any
// loaded bank while the loader rewrites one target bank at a time.
module rom_bank_loader #(
  parameter int                         ADDR_WIDTH = 12,
  parameter int                         DATA_WIDTH = 8,
  parameter int                         BANK_BITS  = 1,
  parameter string                      INIT_FILE  = "../../../roms/basic.hex",
  parameter logic [2**BANK_BITS-1:0]    INIT_VALID = {(2**BANK_BITS){1'b1}},
  parameter logic [DATA_WIDTH-1:0]      FILL_VALUE = 8'hFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cs,
  input  logic [BANK_BITS-1:0]      bank_sel,
  input  logic [ADDR_WIDTH-1:0]     address,
  output logic [DATA_WIDTH-1:0]     dout,
  input  logic                      dl_active,
  input  logic [BANK_BITS-1:0]      dl_bank,
  input  logic                      dl_wr,
  input  logic [ADDR_WIDTH:0]       dl_addr,
  input  logic [DATA_WIDTH-1:0]     dl_data,
  output logic                      busy,
  output logic [2**BANK_BITS-1:0]   loaded,
  output logic [ADDR_WIDTH:0]       dl_count,
  output logic [DATA_WIDTH-1:0]     dl_sum,
  output logic                      dl_ovf
);

  localparam int NUM_BANKS = 2**BANK_BITS;
  localparam int DEPTH     = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t                  state;
  logic [BANK_BITS-1:0]    tgt_bank;
  logic                    dl_active_q;

  logic [DATA_WIDTH-1:0]   mem [0:NUM_BANKS*DEPTH-1];
  logic [DATA_WIDTH-1:0]   rd_q;
  logic                    fill_q;
  logic                    zero_q;
  logic                    wr_en;

  // Only in-range writes during LOAD reach the array; the MSB flags overflow.
  assign wr_en = (state == LOAD) && dl_wr && !dl_addr[ADDR_WIDTH];

  // Single write port plus single read port, read-first, no reset: maps to one block RAM.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[{tgt_bank, dl_addr[ADDR_WIDTH-1:0]}] <= dl_data;
    if (cs)
      rd_q <= mem[{bank_sel, address}];
  end

  // Per-read qualifiers kept beside the RAM output so the RAM itself stays reset-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b1;
      fill_q <= 1'b0;
    end else if (cs) begin
      zero_q <= 1'b0;
      fill_q <= !loaded[bank_sel] || (busy && (bank_sel == tgt_bank));
    end
  end

  // All selects are registered, so dout changes only on clk.
  assign dout = zero_q ? '0 : (fill_q ? FILL_VALUE : rd_q);

  // Download FSM: IDLE -> LOAD on dl_active rise, LOAD -> COMMIT on fall, one-cycle COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      tgt_bank    <= '0;
      dl_active_q <= 1'b0;
      dl_count    <= '0;
      dl_sum      <= '0;
      dl_ovf      <= 1'b0;
      loaded      <= INIT_VALID;
    end else begin
      dl_active_q <= dl_active;
      case (state)
        IDLE: begin
          if (dl_active && !dl_active_q) begin
            state            <= LOAD;
            busy             <= 1'b1;
            tgt_bank         <= dl_bank;
            dl_count         <= '0;
            dl_sum           <= '0;
            dl_ovf           <= 1'b0;
            loaded[dl_bank]  <= 1'b0;
          end
        end
        LOAD: begin
          if (dl_wr) begin
            if (!dl_addr[ADDR_WIDTH]) begin
              if (dl_count != COUNT_MAX)
                dl_count <= dl_count + (ADDR_WIDTH+1)'(1);
              dl_sum <= dl_sum + dl_data;
            end else begin
              dl_ovf <= 1'b1;
            end
          end
          if (!dl_active)
            state <= COMMIT;
        end
        COMMIT: begin
          if (dl_count != '0)
            loaded[tgt_bank] <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_bank_loader.sv
// Self-checking bench for rom_bank_loader: table-driven reads plus
// hand-written download, overflow, empty-load and reset-mid-load sequences.
module tb_rom_bank_loader;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int BB    = 1;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs;
  logic [BB-1:0] bank_sel;
  logic [AW-1:0] address;
  logic [DW-1:0] dout;
  logic          dl_active;
  logic [BB-1:0] dl_bank;
  logic          dl_wr;
  logic [AW:0]   dl_addr;
  logic [DW-1:0] dl_data;
  logic          busy;
  logic [1:0]    loaded;
  logic [AW:0]   dl_count;
  logic [DW-1:0] dl_sum;
  logic          dl_ovf;

  rom_bank_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_BITS(BB),
    .INIT_FILE(""), .INIT_VALID(2'b11), .FILL_VALUE(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .cs(cs), .bank_sel(bank_sel), .address(address),
    .dout(dout), .dl_active(dl_active), .dl_bank(dl_bank), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .busy(busy), .loaded(loaded),
    .dl_count(dl_count), .dl_sum(dl_sum), .dl_ovf(dl_ovf)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [7:0]   exp_q [$];
  logic [7:0]   mdl   [0:2*DEPTH-1];

  typedef struct {
    logic       cs;
    logic       bank;
    logic [11:0] addr;
    logic [7:0] exp;
    string      name;
  } vec_t;
  vec_t tv [8];

  // Reference images: bank 0 and bank 1 get unrelated patterns.
  function automatic logic [7:0] img(int b, int a);
    if (b == 0) return 8'(a * 7 + 1);
    else        return 8'((a ^ (a >> 4)) ^ 8'hC3);
  endfunction

  function automatic logic [7:0] dgen(int kind, int b, int a);
    case (kind)
      0:       return img(b, a);
      1:       return 8'(a);
      default: return ~8'(a);
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock; any read issued for this edge is popped and compared.
  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("dout", 32'(dout), 32'(e));
    end
  endtask

  task automatic rd(bit c, int b, int a, logic [7:0] e);
    cs       = c;
    bank_sel = b[0];
    address  = 12'(a);
    exp_q.push_back(e);
    tick();
    cs = 1'b0;
  endtask

  // Full-bank download; the last write shares its cycle with dl_active falling.
  // With spy set, interleaves CPU reads of both banks and watches busy.
  task automatic download(int b, int kind, bit spy, output logic [7:0] sum);
    logic [7:0] d;
    int rb, ra;
    sum       = 8'h00;
    dl_bank   = b[0];
    dl_active = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      d = dgen(kind, b, i);
      dl_wr   = 1'b1;
      dl_addr = 13'(i);
      dl_data = d;
      mdl[b*DEPTH + i] = d;
      sum = sum + d;
      if (i == DEPTH-1) dl_active = 1'b0;
      if (spy) begin
        rb = i & 1;
        ra = (i * 37) % DEPTH;
        cs = 1'b1;
        bank_sel = rb[0];
        address  = 12'(ra);
        exp_q.push_back((rb == b) ? 8'hFF : mdl[rb*DEPTH + ra]);
      end
      tick();
      cs = 1'b0;
      if (spy) chk("busy_load", 32'(busy), 32'd1);
    end
    dl_wr = 1'b0;
    tick();
    tick();
  endtask

  logic [7:0] s;

  initial begin
    // Read vectors against the reference images (loaded below via the port).
    tv[0] = '{1'b1, 1'b0, 12'h000, img(0, 0),    "b0_000"};
    tv[1] = '{1'b0, 1'b1, 12'h123, img(0, 0),    "hold"};
    tv[2] = '{1'b1, 1'b1, 12'hFFF, img(1, 4095), "b1_fff"};
    tv[3] = '{1'b1, 1'b0, 12'hFFF, img(0, 4095), "b0_fff"};
    tv[4] = '{1'b1, 1'b1, 12'h000, img(1, 0),    "b1_000"};
    tv[5] = '{1'b1, 1'b0, 12'h800, img(0, 2048), "b0_800"};
    tv[6] = '{1'b0, 1'b0, 12'h001, img(0, 2048), "hold2"};
    tv[7] = '{1'b1, 1'b1, 12'h5A5, img(1, 12'h5A5), "b1_5a5"};

    reset = 1'b1; cs = 1'b0; bank_sel = '0; address = '0;
    dl_active = 1'b0; dl_bank = '0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    tick();
    tick();
    chk("rst_dout",   32'(dout),     32'h0);
    chk("rst_busy",   32'(busy),     32'h0);
    chk("rst_loaded", 32'(loaded),   32'h3);
    chk("rst_count",  32'(dl_count), 32'h0);
    chk("rst_sum",    32'(dl_sum),   32'h0);
    chk("rst_ovf",    32'(dl_ovf),   32'h0);
    reset = 1'b0;
    tick();

    // Stand-in for the preload image: fill both banks through the loader.
    download(0, 0, 1'b0, s);
    chk("pre0_count", 32'(dl_count), 32'd4096);
    chk("pre0_sum",   32'(dl_sum),   32'(s));
    download(1, 0, 1'b0, s);
    chk("pre1_loaded", 32'(loaded), 32'h3);

    for (int i = 0; i < 8; i++) rd(tv[i].cs, int'(tv[i].bank), int'(tv[i].addr), tv[i].exp);

    // Full download to bank 1 with data = addr[7:0], reads interleaved.
    download(1, 1, 1'b1, s);
    chk("full_count",  32'(dl_count), 32'd4096);
    chk("full_sum",    32'(dl_sum),   32'h00);
    chk("full_loaded", 32'(loaded),   32'h3);
    chk("full_busy",   32'(busy),     32'h0);
    rd(1'b1, 1, 12'h0A5, 8'hA5);
    rd(1'b1, 0, 12'h0A5, img(0, 12'h0A5));

    // Overflowing write is dropped; one good write lets the bank commit.
    dl_bank = 1'b1; dl_active = 1'b1; tick();
    dl_wr = 1'b1; dl_addr = 13'h1000; dl_data = 8'h77; tick();
    dl_wr = 1'b0;
    chk("ovf_flag",  32'(dl_ovf),   32'h1);
    chk("ovf_count", 32'(dl_count), 32'h0);
    dl_wr = 1'b1; dl_addr = 13'h0005; dl_data = 8'h11; mdl[DEPTH+5] = 8'h11; tick();
    dl_wr = 1'b0; dl_active = 1'b0; tick(); tick(); tick();
    chk("ovf_sticky", 32'(dl_ovf),   32'h1);
    chk("ovf_count1", 32'(dl_count), 32'h1);
    chk("ovf_sum",    32'(dl_sum),   32'h11);
    chk("ovf_loaded", 32'(loaded),   32'h3);
    rd(1'b1, 1, 0, mdl[DEPTH]);
    rd(1'b1, 1, 5, 8'h11);

    // Write strobes while IDLE must be ignored.
    dl_wr = 1'b1; dl_addr = 13'h0007; dl_data = 8'hEE; tick();
    dl_wr = 1'b0;
    chk("idle_wr_count", 32'(dl_count), 32'h1);
    rd(1'b1, 1, 7, mdl[DEPTH+7]);

    // Empty load: three cycles of dl_active with no writes.
    dl_bank = 1'b0; dl_active = 1'b1; tick(); tick(); tick();
    dl_active = 1'b0; tick(); tick(); tick();
    chk("empty_loaded", 32'(loaded),   32'h2);
    chk("empty_ovf",    32'(dl_ovf),   32'h0);
    chk("empty_count",  32'(dl_count), 32'h0);
    rd(1'b1, 0, 3, 8'hFF);

    // Reset after 100 writes to bank 0.
    dl_bank = 1'b0; dl_active = 1'b1; tick();
    for (int i = 0; i < 100; i++) begin
      dl_wr = 1'b1; dl_addr = 13'(i); dl_data = dgen(2, 0, i);
      mdl[i] = dgen(2, 0, i);
      tick();
    end
    dl_wr = 1'b0;
    chk("mid_count", 32'(dl_count), 32'd100);
    dl_active = 1'b0; reset = 1'b1; tick();
    reset = 1'b0;
    chk("mrst_busy",   32'(busy),     32'h0);
    chk("mrst_count",  32'(dl_count), 32'h0);
    chk("mrst_loaded", 32'(loaded),   32'h3);
    chk("mrst_dout",   32'(dout),     32'h0);
    rd(1'b1, 0, 0,    mdl[0]);
    rd(1'b1, 0, 50,   mdl[50]);
    rd(1'b1, 0, 99,   mdl[99]);
    rd(1'b1, 0, 100,  img(0, 100));
    rd(1'b1, 0, 4095, img(0, 4095));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
